// File: rtl/dual_ram_loader_pkg.sv
// Shared types and constants for the dual-bank RAM loader.
package loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_CHK_W   = 16;

    localparam int BANK_DEPTH  = 512;
    localparam int TOTAL_BYTES = 2 * BANK_DEPTH;

endpackage

// File: rtl/dual_ram_loader_if.sv
// Stream-in / RAM-write-out bundle of the dual-bank loader.
interface dual_ram_loader_if
    import loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CHK_W  = DEF_CHK_W
);
    logic              START_I;
    logic [DATA_W-1:0] DATA_I;
    logic              VALID_I;
    logic              READY_O;
    logic [ADDR_W-1:0] WRITE_ADDRESS_A_O;
    logic [ADDR_W-1:0] WRITE_ADDRESS_B_O;
    logic [DATA_W-1:0] WRITE_DATA_A_O;
    logic [DATA_W-1:0] WRITE_DATA_B_O;
    logic [1:0]        WRITE_ENABLE_A_O;
    logic [1:0]        WRITE_ENABLE_B_O;
    logic [ADDR_W+1:0] BYTE_COUNT_O;
    logic              DONE_O;
    logic [CHK_W-1:0]  CHECKSUM_O;

    // Upstream producer / downstream observer side.
    modport master (
        output START_I, DATA_I, VALID_I,
        input  READY_O, WRITE_ADDRESS_A_O, WRITE_ADDRESS_B_O,
        input  WRITE_DATA_A_O, WRITE_DATA_B_O,
        input  WRITE_ENABLE_A_O, WRITE_ENABLE_B_O,
        input  BYTE_COUNT_O, DONE_O, CHECKSUM_O
    );

    // Loader side.
    modport slave (
        input  START_I, DATA_I, VALID_I,
        output READY_O, WRITE_ADDRESS_A_O, WRITE_ADDRESS_B_O,
        output WRITE_DATA_A_O, WRITE_DATA_B_O,
        output WRITE_ENABLE_A_O, WRITE_ENABLE_B_O,
        output BYTE_COUNT_O, DONE_O, CHECKSUM_O
    );

endinterface

// File: rtl/dual_ram_loader_pair_packer.sv
// Pairs consecutive stream bytes: latches even bytes, emits one registered
// dual-port write (even addr on A, odd addr on B) per odd byte.
module pair_packer
    import loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_p0,
    input  logic [DATA_W-1:0] data_p0,
    input  logic [ADDR_W:0]   idx_p0,
    output logic              vld_p1,
    output logic              bank_p1,
    output logic [ADDR_W-1:0] addr_a_p1,
    output logic [ADDR_W-1:0] addr_b_p1,
    output logic [DATA_W-1:0] data_a_p1,
    output logic [DATA_W-1:0] data_b_p1
);

    logic [DATA_W-1:0] hold_p0;
    logic              odd_p0;

    assign odd_p0 = idx_p0[0];

    // p0 -> p1: even byte parks in hold_p0, odd byte launches the pair write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_p0   <= '0;
            vld_p1    <= 1'b0;
            bank_p1   <= 1'b0;
            addr_a_p1 <= '0;
            addr_b_p1 <= '0;
            data_a_p1 <= '0;
            data_b_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0 && odd_p0;
            if (vld_p0 && !odd_p0) begin
                hold_p0 <= data_p0;
            end
            if (vld_p0 && odd_p0) begin
                bank_p1   <= idx_p0[ADDR_W];
                addr_a_p1 <= {idx_p0[ADDR_W-1:1], 1'b0};
                addr_b_p1 <= idx_p0[ADDR_W-1:0];
                data_a_p1 <= hold_p0;
                data_b_p1 <= data_p0;
            end
        end
    end

endmodule

// File: rtl/dual_ram_loader.sv
// Fills two 512x8 dual-port RAM banks from a byte stream, two bytes per write.
// Optional running checksum of accepted bytes: define LOADER_CHECKSUM_EN.
module dual_ram_loader
    import loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CHK_W  = DEF_CHK_W
)(
    input  logic CLOCK_I,
    input  logic RESET_I,
    dual_ram_loader_if.slave bus
);

    localparam int                CNT_W    = ADDR_W + 2;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TOTAL_BYTES);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(TOTAL_BYTES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
    endfunction

    state_t             state;
    logic               ready_r;
    logic               done_r;
    logic [CNT_W-1:0]   count_r;
    logic               vld_p0;

    logic               vld_p1;
    logic               bank_p1;
    logic [ADDR_W-1:0]  addr_a_p1;
    logic [ADDR_W-1:0]  addr_b_p1;
    logic [DATA_W-1:0]  data_a_p1;
    logic [DATA_W-1:0]  data_b_p1;
    logic [1:0]         we_p1;

    assign vld_p0 = bus.VALID_I && ready_r;

    // Control FSM: ready/done are registered so they never glitch.
    always_ff @(posedge CLOCK_I or posedge RESET_I) begin
        if (RESET_I) begin
            state   <= S_IDLE;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
            count_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.START_I) begin
                        state   <= S_LOAD;
                        ready_r <= 1'b1;
                        count_r <= '0;
                    end
                end
                S_LOAD: begin
                    if (vld_p0) begin
                        count_r <= sat_inc(count_r);
                        if (count_r == LAST_IDX) begin
                            state   <= S_FLUSH;
                            ready_r <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    state  <= S_DONE;
                    done_r <= 1'b1;
                end
                S_DONE: begin
                    if (bus.START_I) begin
                        state   <= S_LOAD;
                        ready_r <= 1'b1;
                        done_r  <= 1'b0;
                        count_r <= '0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_r <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    pair_packer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_pair_packer (
        .clk       (CLOCK_I),
        .rst       (RESET_I),
        .vld_p0    (vld_p0),
        .data_p0   (bus.DATA_I),
        .idx_p0    (count_r[ADDR_W:0]),
        .vld_p1    (vld_p1),
        .bank_p1   (bank_p1),
        .addr_a_p1 (addr_a_p1),
        .addr_b_p1 (addr_b_p1),
        .data_a_p1 (data_a_p1),
        .data_b_p1 (data_b_p1)
    );

    // Bank decode is a pure AND of packer flops, so enables stay glitch-free.
    assign we_p1 = {vld_p1 & bank_p1, vld_p1 & ~bank_p1};

    assign bus.READY_O           = ready_r;
    assign bus.DONE_O            = done_r;
    assign bus.BYTE_COUNT_O      = count_r;
    assign bus.WRITE_ENABLE_A_O  = we_p1;
    assign bus.WRITE_ENABLE_B_O  = we_p1;
    assign bus.WRITE_ADDRESS_A_O = addr_a_p1;
    assign bus.WRITE_ADDRESS_B_O = addr_b_p1;
    assign bus.WRITE_DATA_A_O    = data_a_p1;
    assign bus.WRITE_DATA_B_O    = data_b_p1;

`ifdef LOADER_CHECKSUM_EN
    logic             start_p0;
    logic [CHK_W-1:0] sum_r;

    function automatic logic [CHK_W-1:0] wrap_add(input logic [CHK_W-1:0] s,
                                                   input logic [DATA_W-1:0] d);
        return s + CHK_W'(d);
    endfunction

    assign start_p0 = bus.START_I && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge CLOCK_I or posedge RESET_I) begin
        if (RESET_I) begin
            sum_r <= '0;
        end else if (start_p0) begin
            sum_r <= '0;
        end else if (vld_p0) begin
            sum_r <= wrap_add(sum_r, bus.DATA_I);
        end
    end

    assign bus.CHECKSUM_O = sum_r;
`else
    assign bus.CHECKSUM_O = {CHK_W{1'b0}};
`endif

endmodule

// File: tb/tb_dual_ram_loader.sv
// Directed bench for dual_ram_loader: fills, bank switch, start/valid misuse, async reset.
module tb_dual_ram_loader;
    import loader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dual_ram_loader_if #(.DATA_W(8), .ADDR_W(9), .CHK_W(16)) bus_if ();

    dual_ram_loader #(.DATA_W(8), .ADDR_W(9), .CHK_W(16)) dut (
        .CLOCK_I (clk),
        .RESET_I (rst),
        .bus     (bus_if.slave)
    );

    always #5 clk = ~clk;

`ifdef LOADER_CHECKSUM_EN
    localparam logic [15:0] EXP_SUM = 16'hFE00;
`else
    localparam logic [15:0] EXP_SUM = 16'h0000;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem0 [512];
    logic [7:0] mem1 [512];

    // Reference pairing model driven by the observed handshake.
    bit         mon_on = 1'b0;
    bit         pend   = 1'b0;
    logic [9:0] pend_idx;
    logic [7:0] pend_da;
    logic [7:0] pend_db;
    logic [7:0] held;
    int         mcount = 0;
    int         pulses = 0;
    logic [1:0] exp_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mems();
        for (int k = 0; k < 512; k++) begin
            mem0[k] = ~k[7:0];
            mem1[k] = ~k[7:0];
        end
    endtask

    task automatic verify_ram(input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            if (mem0[k] !== k[7:0]) bad++;
            if (mem1[k] !== k[7:0]) bad++;
        end
        check(tag, bad, 0);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            exp_we = pend ? (pend_idx[9] ? 2'b10 : 2'b01) : 2'b00;
            check("we_a", {30'd0, bus_if.WRITE_ENABLE_A_O}, {30'd0, exp_we});
            check("we_b", {30'd0, bus_if.WRITE_ENABLE_B_O}, {30'd0, exp_we});
            if (pend) begin
                pulses++;
                check("addr_a", {23'd0, bus_if.WRITE_ADDRESS_A_O}, {23'd0, pend_idx[8:1], 1'b0});
                check("addr_b", {23'd0, bus_if.WRITE_ADDRESS_B_O}, {23'd0, pend_idx[8:0]});
                check("data_a", {24'd0, bus_if.WRITE_DATA_A_O}, {24'd0, pend_da});
                check("data_b", {24'd0, bus_if.WRITE_DATA_B_O}, {24'd0, pend_db});
            end
            if (bus_if.WRITE_ENABLE_A_O[0]) mem0[bus_if.WRITE_ADDRESS_A_O] = bus_if.WRITE_DATA_A_O;
            if (bus_if.WRITE_ENABLE_A_O[1]) mem1[bus_if.WRITE_ADDRESS_A_O] = bus_if.WRITE_DATA_A_O;
            if (bus_if.WRITE_ENABLE_B_O[0]) mem0[bus_if.WRITE_ADDRESS_B_O] = bus_if.WRITE_DATA_B_O;
            if (bus_if.WRITE_ENABLE_B_O[1]) mem1[bus_if.WRITE_ADDRESS_B_O] = bus_if.WRITE_DATA_B_O;
            check("count", {21'd0, bus_if.BYTE_COUNT_O}, mcount);
            if (bus_if.VALID_I && bus_if.READY_O) begin
                if (mcount[0]) begin
                    pend     = 1'b1;
                    pend_idx = mcount[9:0];
                    pend_da  = held;
                    pend_db  = bus_if.DATA_I;
                end else begin
                    held = bus_if.DATA_I;
                    pend = 1'b0;
                end
                mcount++;
            end else begin
                pend = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int iters;
        held = '0;
        bus_if.START_I = 1'b0;
        bus_if.VALID_I = 1'b0;
        bus_if.DATA_I  = '0;
        clear_mems();

        repeat (3) tick();
        check("rst_ready", {31'd0, bus_if.READY_O}, 0);
        check("rst_count", {21'd0, bus_if.BYTE_COUNT_O}, 0);
        rst = 1'b0;
        tick();
        check("idle_done", {31'd0, bus_if.DONE_O}, 0);
        check("idle_we", {30'd0, bus_if.WRITE_ENABLE_A_O | bus_if.WRITE_ENABLE_B_O}, 0);
        check("idle_sum", {16'd0, bus_if.CHECKSUM_O}, 0);

        // VALID without START is ignored in idle
        bus_if.VALID_I = 1'b1;
        bus_if.DATA_I  = 8'h5A;
        tick();
        tick();
        check("idle_valid_ready", {31'd0, bus_if.READY_O}, 0);
        check("idle_valid_count", {21'd0, bus_if.BYTE_COUNT_O}, 0);
        bus_if.VALID_I = 1'b0;

        // Continuous fill, with a START pulse at byte 300 that must be ignored
        mon_on = 1'b1;
        bus_if.START_I = 1'b1;
        tick();
        bus_if.START_I = 1'b0;
        mcount = 0;
        check("start_ready", {31'd0, bus_if.READY_O}, 1);
        for (int i = 0; i < 1024; i++) begin
            bus_if.DATA_I  = i[7:0];
            bus_if.VALID_I = 1'b1;
            bus_if.START_I = (i == 300);
            tick();
            if (i == 300) check("start_ignored_count", {21'd0, bus_if.BYTE_COUNT_O}, 301);
            if (i == 511) begin
                check("bank0_we_a", {30'd0, bus_if.WRITE_ENABLE_A_O}, 32'd1);
                check("bank0_we_b", {30'd0, bus_if.WRITE_ENABLE_B_O}, 32'd1);
                check("bank0_addr_a", {23'd0, bus_if.WRITE_ADDRESS_A_O}, 510);
                check("bank0_addr_b", {23'd0, bus_if.WRITE_ADDRESS_B_O}, 511);
                check("bank0_data_a", {24'd0, bus_if.WRITE_DATA_A_O}, 32'hFE);
                check("bank0_data_b", {24'd0, bus_if.WRITE_DATA_B_O}, 32'hFF);
            end
            if (i == 513) begin
                check("bank1_we_a", {30'd0, bus_if.WRITE_ENABLE_A_O}, 32'd2);
                check("bank1_we_b", {30'd0, bus_if.WRITE_ENABLE_B_O}, 32'd2);
                check("bank1_addr_a", {23'd0, bus_if.WRITE_ADDRESS_A_O}, 0);
                check("bank1_addr_b", {23'd0, bus_if.WRITE_ADDRESS_B_O}, 1);
                check("bank1_data_b", {24'd0, bus_if.WRITE_DATA_B_O}, 1);
            end
        end
        bus_if.VALID_I = 1'b0;
        bus_if.START_I = 1'b0;
        check("flush_ready", {31'd0, bus_if.READY_O}, 0);
        check("flush_done", {31'd0, bus_if.DONE_O}, 0);
        check("flush_we_a", {30'd0, bus_if.WRITE_ENABLE_A_O}, 32'd2);
        check("flush_addr_b", {23'd0, bus_if.WRITE_ADDRESS_B_O}, 511);
        tick();
        check("fill_done", {31'd0, bus_if.DONE_O}, 1);
        check("fill_count", {21'd0, bus_if.BYTE_COUNT_O}, 1024);
        check("fill_sum", {16'd0, bus_if.CHECKSUM_O}, {16'd0, EXP_SUM});
        check("fill_pulses", pulses, 512);
        verify_ram("fill_ram");

        // VALID in S_DONE is ignored and DONE holds
        bus_if.VALID_I = 1'b1;
        tick();
        tick();
        check("done_hold", {31'd0, bus_if.DONE_O}, 1);
        check("done_count_sat", {21'd0, bus_if.BYTE_COUNT_O}, 1024);
        bus_if.VALID_I = 1'b0;

        // Restart from S_DONE, then a gapped stream
        bus_if.START_I = 1'b1;
        tick();
        bus_if.START_I = 1'b0;
        mcount = 0;
        pulses = 0;
        clear_mems();
        check("restart_done", {31'd0, bus_if.DONE_O}, 0);
        check("restart_count", {21'd0, bus_if.BYTE_COUNT_O}, 0);
        check("restart_ready", {31'd0, bus_if.READY_O}, 1);
        check("restart_sum", {16'd0, bus_if.CHECKSUM_O}, 0);
        n = 0;
        iters = 0;
        while (n < 1024 && iters < 5000) begin
            if ($urandom_range(1, 0) == 1) begin
                bus_if.DATA_I  = n[7:0];
                bus_if.VALID_I = 1'b1;
                n++;
            end else begin
                bus_if.DATA_I  = 8'($urandom);
                bus_if.VALID_I = 1'b0;
            end
            tick();
            iters++;
        end
        bus_if.VALID_I = 1'b0;
        check("gap_bound", n, 1024);
        tick();
        check("gap_done", {31'd0, bus_if.DONE_O}, 1);
        check("gap_sum", {16'd0, bus_if.CHECKSUM_O}, {16'd0, EXP_SUM});
        check("gap_pulses", pulses, 512);
        verify_ram("gap_ram");

        // Third load aborted by an asynchronous reset at byte 700
        bus_if.START_I = 1'b1;
        tick();
        bus_if.START_I = 1'b0;
        mcount = 0;
        for (int i = 0; i < 700; i++) begin
            bus_if.DATA_I  = i[7:0];
            bus_if.VALID_I = 1'b1;
            tick();
        end
        check("pre_reset_count", {21'd0, bus_if.BYTE_COUNT_O}, 700);
        bus_if.DATA_I = 8'd188;
        mon_on = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_ready", {31'd0, bus_if.READY_O}, 0);
        check("arst_done", {31'd0, bus_if.DONE_O}, 0);
        check("arst_count", {21'd0, bus_if.BYTE_COUNT_O}, 0);
        check("arst_we", {28'd0, bus_if.WRITE_ENABLE_A_O, bus_if.WRITE_ENABLE_B_O}, 0);
        check("arst_addr", {14'd0, bus_if.WRITE_ADDRESS_A_O, bus_if.WRITE_ADDRESS_B_O}, 0);
        check("arst_data", {16'd0, bus_if.WRITE_DATA_A_O, bus_if.WRITE_DATA_B_O}, 0);
        check("arst_sum", {16'd0, bus_if.CHECKSUM_O}, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_ready", {31'd0, bus_if.READY_O}, 0);
        check("post_rst_count", {21'd0, bus_if.BYTE_COUNT_O}, 0);
        check("post_rst_done", {31'd0, bus_if.DONE_O}, 0);
        bus_if.VALID_I = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_ram_loader.md
Name: dual_ram_loader

Overview:
Upstream fill stage for the dual-bank compute block. It accepts a byte stream over a valid/ready handshake and writes 1024 bytes into two 512x8 dual-port RAMs: bytes 0..511 go to RAM0 and bytes 512..1023 go to RAM1. Each pair of consecutive bytes is written in one cycle, using port A for the even address and port B for the odd address. DONE_O tells the downstream compute FSM that the RAM contents are valid.

Parameters:
- DATA_W, 8, byte width of the stream and of the RAM words.
- ADDR_W, 9, RAM address width; each bank has depth 2**ADDR_W = 512.
- CHK_W, 16, checksum width (used only with the optional feature).

Ports:
- CLOCK_I  input  1  single system clock; all logic on the rising edge.
- RESET_I  input  1  asynchronous, active-high reset.
- START_I  input  1  one-cycle pulse that begins a load; honoured only in S_IDLE or S_DONE.
- DATA_I  input  DATA_W  stream byte.
- VALID_I  input  1  DATA_I is valid.
- READY_O  output  1  loader can accept a byte this cycle.
- WRITE_ADDRESS_A_O  output  ADDR_W  port-A address (even byte).
- WRITE_ADDRESS_B_O  output  ADDR_W  port-B address (odd byte, equals A+1).
- WRITE_DATA_A_O  output  DATA_W  port-A write data.
- WRITE_DATA_B_O  output  DATA_W  port-B write data.
- WRITE_ENABLE_A_O  output  2  per-bank port-A write enable; bit 0 = RAM0, bit 1 = RAM1.
- WRITE_ENABLE_B_O  output  2  per-bank port-B write enable.
- BYTE_COUNT_O  output  ADDR_W+2  number of bytes accepted so far in this load (0..1024).
- DONE_O  output  1  load complete; held high until the next accepted START_I or reset.
- CHECKSUM_O  output  CHK_W  running sum of accepted bytes.

Behaviour:
- Clocking/reset: one clock, CLOCK_I. Reset is asynchronous and active-high on RESET_I.
- Reset values: all outputs 0, state S_IDLE, pair holding register cleared.
- States:
  - S_IDLE: READY_O=0. START_I goes to S_LOAD and clears BYTE_COUNT_O and CHECKSUM_O.
  - S_LOAD: READY_O=1. A byte is accepted when VALID_I && READY_O.
  - S_FLUSH: one cycle. Issues the final pair write, with READY_O=0.
  - S_DONE: DONE_O=1, READY_O=0. START_I goes to S_LOAD and clears DONE_O, the count and the checksum in the same edge.
- Byte index n = BYTE_COUNT_O at acceptance. Target bank = n[ADDR_W]; target address = n[ADDR_W-1:0].
- Even n: the byte is latched in the holding register and no write occurs.
- Odd n: on the next cycle, exactly one bank's A and B enables pulse high for one cycle.
  - Port A: address n-1, data = held byte.
  - Port B: address n, data = this byte.
  - Write latency is 1 cycle after the odd byte is accepted. All write outputs are registered.
- Throughput is one byte per cycle. READY_O never deasserts mid-load, so no back-pressure is needed.
- When VALID_I is low, nothing is accepted and the holding register keeps its byte indefinitely.
- When byte 1023 is accepted, the FSM goes to S_FLUSH; the final write happens there. DONE_O rises on the following edge, i.e. 2 cycles after the last accept.
- Enables are 0 whenever no pair write is in progress. At most 2 of the 4 enable bits are high at once, and both always belong to the same bank.
- Boundary conditions:
  - START_I during S_LOAD or S_FLUSH is ignored.
  - VALID_I outside S_LOAD is ignored.
  - BYTE_COUNT_O saturates at 1024.
  - Bank switch: byte 512 targets RAM1 address 0.
  - RESET_I mid-load aborts immediately; RAM contents are then undefined and DONE_O=0.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: CHECKSUM_O adds each accepted byte, zero-extended, modulo 2**CHK_W, updated on the accept edge.
- Undefined: the accumulator is not built and CHECKSUM_O is tied to 0.

Decomposition:
- Shared package loader_pkg holds:
  - the state enum (S_IDLE, S_LOAD, S_FLUSH, S_DONE);
  - constants BANK_DEPTH = 512 and TOTAL_BYTES = 1024;
  - the default widths.
- One natural sub-module, pair_packer: holding register plus odd/even pairing, emitting a registered pair-write strobe, address and data. The top level keeps the FSM, counter, bank decode and checksum.

Test Plan:
- Continuous fill: START_I, then 1024 bytes with DATA_I = n mod 256 and VALID_I high throughout. Expected: RAM0[k] = k mod 256, RAM1[k] = k mod 256; 512 write pulses; DONE_O high 2 cycles after the last accept; BYTE_COUNT_O = 1024.
- Gapped stream: VALID_I toggled randomly at a 50% duty cycle. Expected: identical RAM contents; pair writes appear only 1 cycle after odd-indexed accepts.
- Bank boundary: accept bytes 510/511. Expected: WRITE_ENABLE_A/B_O = 2'b01 at addresses 510/511. Then bytes 512/513. Expected: 2'b10 at addresses 0/1.
- START_I pulsed at byte 300. Expected: ignored, count continues to 301. START_I in S_DONE. Expected: DONE_O=0, count=0, READY_O=1 the next cycle.
- RESET_I asserted at byte 700. Expected: all outputs 0 and state S_IDLE immediately, asynchronously; VALID_I afterwards gives READY_O=0.
- With LOADER_CHECKSUM_EN and the continuous-fill pattern: CHECKSUM_O = 16'hFE00 at DONE_O. Without the macro: CHECKSUM_O = 0 throughout.
